// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer-side and FIFO-side signals of the
// shared write port, bundled for the round-robin arbiter.
interface fifo_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_full;
  logic                    fifo_write_en;
  logic [DATA_W-1:0]       fifo_data_in;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;

  // Arbiter side.
  modport master (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_full,
    output req_ready,
    output fifo_write_en,
    output fifo_data_in,
    output grant_id,
    output busy
  );

  // Producers and FIFO side.
  modport slave (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_full,
    input  req_ready,
    input  fifo_write_en,
    input  fifo_data_in,
    input  grant_id,
    input  busy
  );

endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin owner of a single FIFO write port.
// One producer holds the port for a bounded burst; full stalls it.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  rst,
  fifo_write_arbiter_if.master bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              xfer;
  logic [CNT_W-1:0]  beat_inc;
  logic              burst_end;
  logic              abandon;
  logic [ID_W-1:0]   owner_nxt;

  // Index rr_ptr+k wrapped into 0..N_REQ-1 (k < N_REQ).
  function automatic logic [ID_W-1:0] rr_idx(
    input logic [ID_W-1:0] base,
    input int              k
  );
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // First valid requester at or after rr_ptr; reverse scan so the
  // smallest offset wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(rr_ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(rr_ptr_q, k);
      end
    end
  end

  // Mux out the current owner's lane.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transfer and release conditions.
  always_comb begin
    xfer      = (state_q == OWN) && own_valid && !bus.fifo_full;
    beat_inc  = beat_cnt_q + CNT_W'(1);
    burst_end = own_last || (beat_inc == CNT_W'(MAX_BURST));
    abandon   = (state_q == OWN) && !own_valid && !bus.fifo_full;
    if (owner_q == ID_W'(N_REQ - 1)) owner_nxt = '0;
    else                             owner_nxt = owner_q + ID_W'(1);
  end

  // Port outputs: only the owner sees ready, and only when not full.
  always_comb begin
    bus.req_ready     = '0;
    bus.fifo_write_en = 1'b0;
    bus.fifo_data_in  = '0;
    bus.grant_id      = owner_q;
    bus.busy          = (state_q == OWN);
    if (state_q == OWN) begin
      bus.req_ready[owner_q] = !bus.fifo_full;
    end
    if (xfer) begin
      bus.fifo_write_en = 1'b1;
      bus.fifo_data_in  = own_data;
    end
  end

  // Grant / burst / release sequencing.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = OWN;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        if (xfer) begin
          beat_cnt_d = beat_inc;
          if (burst_end) begin
            state_d    = IDLE;
            rr_ptr_d   = owner_nxt;
            beat_cnt_d = '0;
          end
        end else if (abandon) begin
          state_d    = IDLE;
          rr_ptr_d   = owner_nxt;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scenario tasks checked cycle by cycle
// against a behavioural model of the arbitration rules.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk;
  logic rst;

  fifo_write_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  fifo_write_arbiter #(
    .N_REQ(N), .DATA_W(W), .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // model state
  bit m_busy;
  int m_owner;
  int m_rr;
  int m_beats;

  // expected outputs packed like obs
  logic [15:0] exp_v;
  logic [15:0] obs;
  assign obs = {bus.req_ready, bus.fifo_write_en, bus.fifo_data_in,
                bus.grant_id, bus.busy};

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_rr    = 0;
    m_beats = 0;
  endtask

  task automatic model_out();
    logic [3:0] r;
    logic       we;
    logic [7:0] d;
    r  = '0;
    we = 1'b0;
    d  = '0;
    if (m_busy) begin
      if (!bus.fifo_full) r[m_owner] = 1'b1;
      if (bus.req_valid[m_owner] && !bus.fifo_full) begin
        we = 1'b1;
        d  = bus.req_data[m_owner*W +: W];
      end
    end
    exp_v = {r, we, d, 2'(m_owner), m_busy};
  endtask

  task automatic model_edge();
    bool_rel: begin end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && bus.req_valid[(m_rr + k) % N]) begin
          m_busy  = 1;
          m_owner = (m_rr + k) % N;
          m_beats = 0;
        end
      end
    end else if (bus.req_valid[m_owner] && !bus.fifo_full) begin
      m_beats++;
      if (bus.req_last[m_owner] || m_beats == MB) begin
        m_busy  = 0;
        m_rr    = (m_owner + 1) % N;
        m_beats = 0;
      end
    end else if (!bus.req_valid[m_owner] && !bus.fifo_full) begin
      m_busy  = 0;
      m_rr    = (m_owner + 1) % N;
      m_beats = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    model_reset();
    #3;
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 16'h0);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] a [3];
    int b;
    int wr;
    do_reset();
    for (int i = 0; i < 3; i++) a[i] = 8'($urandom);
    b  = 0;
    wr = 0;
    for (int c = 0; c < 5; c++) begin
      clear_in();
      if (b < 3) begin
        bus.req_valid[2]       = 1'b1;
        bus.req_data[2*W +: W] = a[b];
        bus.req_last[2]        = (b == 2);
      end
      #2;
      model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single cyc%0d: got %h expected %h", c, obs, exp_v);
      end
      if (bus.fifo_write_en) wr++;
      if (exp_v[11]) b++;
      tick();
    end
    n_tests++;
    if (wr !== 3) begin
      n_fail++;
      $display("FAIL single_count: got %0d expected 3", wr);
    end
    n_tests++;
    if (int'(dut.rr_ptr_q) !== 3) begin
      n_fail++;
      $display("FAIL single_rr: got %0d expected 3", dut.rr_ptr_q);
    end
  endtask

  task automatic test_round_robin();
    int gq [$];
    int cq [$];
    int exp_g [5];
    logic prev_busy;
    do_reset();
    exp_g     = '{0, 1, 2, 3, 0};
    prev_busy = 1'b0;
    for (int c = 0; c < 25; c++) begin
      bus.req_valid = '1;
      bus.req_last  = '0;
      bus.fifo_full = 1'b0;
      bus.req_data  = 32'($urandom);
      #2;
      model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rr cyc%0d: got %h expected %h", c, obs, exp_v);
      end
      if (bus.busy && !prev_busy) begin
        gq.push_back(int'(bus.grant_id));
        cq.push_back(0);
      end
      if (bus.fifo_write_en && cq.size() > 0) cq[cq.size()-1]++;
      prev_busy = bus.busy;
      tick();
    end
    n_tests++;
    if (gq.size() !== 5) begin
      n_fail++;
      $display("FAIL rr_grants: got %0d expected 5", gq.size());
    end
    for (int g = 0; g < 5 && g < gq.size(); g++) begin
      n_tests++;
      if (gq[g] !== exp_g[g] || cq[g] !== MB) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got id %0d beats %0d expected id %0d beats %0d",
                 g, gq[g], cq[g], exp_g[g], MB);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a [4];
    int b;
    int wr;
    do_reset();
    m_rr = 0;
    for (int i = 0; i < 4; i++) a[i] = 8'($urandom);
    b  = 0;
    wr = 0;
    for (int c = 0; c < 9; c++) begin
      clear_in();
      bus.fifo_full = (c >= 3 && c <= 5);
      if (b < 4) begin
        bus.req_valid[1]       = 1'b1;
        bus.req_data[1*W +: W] = a[b];
      end
      #2;
      model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp cyc%0d: got %h expected %h", c, obs, exp_v);
      end
      if (bus.fifo_full) begin
        n_tests++;
        if (bus.req_ready[1] !== 1'b0 || int'(dut.beat_cnt_q) !== 2
            || bus.fifo_write_en !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_stall cyc%0d: got rdy=%b cnt=%0d we=%b expected 0 2 0",
                   c, bus.req_ready[1], dut.beat_cnt_q, bus.fifo_write_en);
        end
      end
      if (bus.fifo_write_en) wr++;
      if (exp_v[11]) b++;
      tick();
    end
    n_tests++;
    if (wr !== 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d expected 4", wr);
    end
  endtask

  task automatic test_abandon();
    int wr0;
    do_reset();
    wr0 = 0;
    for (int c = 0; c < 5; c++) begin
      clear_in();
      bus.req_valid[3]       = (c < 4);
      bus.req_last[3]        = 1'b1;
      bus.req_data[3*W +: W] = 8'($urandom);
      bus.req_valid[0]       = (c == 0);
      bus.req_data[0*W +: W] = 8'($urandom);
      #2;
      model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL abandon cyc%0d: got %h expected %h", c, obs, exp_v);
      end
      if (c == 1 && bus.fifo_write_en) wr0++;
      if (c == 2) begin
        n_tests++;
        if (int'(dut.rr_ptr_q) !== 1 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL abandon_rr: got rr=%0d busy=%b expected 1 0",
                   dut.rr_ptr_q, bus.busy);
        end
      end
      if (c == 3) begin
        n_tests++;
        if (bus.grant_id !== 2'd3 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL abandon_next: got id=%0d busy=%b expected 3 1",
                   bus.grant_id, bus.busy);
        end
      end
      tick();
    end
    n_tests++;
    if (wr0 !== 0) begin
      n_fail++;
      $display("FAIL abandon_writes: got %0d expected 0", wr0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clear_in();
      bus.req_valid[0]       = 1'b1;
      bus.req_data[0*W +: W] = 8'($urandom);
      #2;
      model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid cyc%0d: got %h expected %h", c, obs, exp_v);
      end
      if (c < 2) tick();
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected %h", obs, 16'h0);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (obs !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid_hold: got %h expected %h", obs, 16'h0);
    end
    clear_in();
    bus.req_valid[2]       = 1'b1;
    bus.req_last[2]        = 1'b1;
    bus.req_data[2*W +: W] = 8'($urandom);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_post cyc%0d: got %h expected %h", c, obs, exp_v);
      end
      if (c == 1) begin
        n_tests++;
        if (bus.grant_id !== 2'd2 || bus.fifo_write_en !== 1'b1) begin
          n_fail++;
          $display("FAIL rstmid_grant: got id=%0d we=%b expected 2 1",
                   bus.grant_id, bus.fifo_write_en);
        end
        bus.req_valid = '0;
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = 4'($urandom) | 4'($urandom);
      bus.req_last  = 4'($urandom) & 4'($urandom);
      bus.req_data  = 32'($urandom);
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      #2;
      model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares one 8-bit FIFO write port between N_REQ independent producers. It sits directly in front of the FIFO and owns its `write_en`/`data_in` inputs. It grants one producer at a time for a bounded burst. FIFO back-pressure (`full`) is propagated to the granted producer through a valid/ready handshake.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8
- DATA_W, 8, beat width; must match FIFO data width
- MAX_BURST, 4, maximum beats per grant; legal range 1..16
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_W  per-requester beat; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  marks final beat of requester's burst
- req_ready  out  N_REQ  per-requester accept; at most one bit high
- fifo_full  in  1  FIFO full flag
- fifo_write_en  out  1  FIFO write strobe
- fifo_data_in  out  DATA_W  FIFO write data
- grant_id  out  max(1,$clog2(N_REQ))  index of current/last owner
- busy  out  1  high while a grant is held (state OWN)

## Operation
- State: `state` (IDLE/OWN), `owner`, `rr_ptr`, and `beat_cnt`. `beat_cnt` is wide enough to hold MAX_BURST.
- Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0. Outputs during reset: req_ready=0, fifo_write_en=0, fifo_data_in=0, grant_id=0, busy=0.
- IDLE:
  - If any req_valid is high, choose the first requester i with req_valid[i]=1, scanning i = rr_ptr, rr_ptr+1, … modulo N_REQ.
  - On that edge: owner<=i, beat_cnt<=0, state<=OWN.
  - No writes occur in IDLE.
- OWN:
  - req_ready[owner] = !fifo_full (combinational); all other req_ready bits are 0.
  - Transfer when req_valid[owner] && req_ready[owner]. On a transfer: fifo_write_en=1, fifo_data_in=req_data[owner], and beat_cnt increments.
  - When there is no transfer: fifo_write_en=0 and fifo_data_in=0.
- Release from OWN to IDLE, at the edge, when any of the following holds:
  - a transfer with req_last[owner]=1;
  - a transfer that makes beat_cnt reach MAX_BURST;
  - req_valid[owner]=0 while fifo_full=0 (the producer abandoned the grant).
- On release: rr_ptr <= (owner+1) mod N_REQ, and beat_cnt <= 0.
- fifo_full during OWN:
  - Ownership is held indefinitely.
  - beat_cnt is frozen and no write occurs.
  - req_valid low while full does not release the grant.
- grant_id = owner at all times. busy = (state==OWN).
- Inputs from non-owners are ignored while in OWN.
- Asynchronous rst mid-burst: the block returns to IDLE immediately, the partial burst is abandoned, and no further writes occur.

## Timing
- Grant latency: req_valid rising in IDLE during cycle 0 gives busy=1 and req_ready[owner]=1 in cycle 1. The first beat is written at the end of cycle 1.
- Within a grant: one beat per cycle while fifo_full=0.
- Between grants: exactly one IDLE bubble cycle with no write.
- fifo_write_en/fifo_data_in are combinational from registered state plus fifo_full/req_valid/req_data. The FIFO samples them on the same edge.
- fifo_full is registered-derived inside the FIFO, so no combinational loop exists.

## Test plan
- Single requester: req_valid[2] held for 3 beats (A1,A2,A3), req_last on A3.
  - Required: busy in cycle 1; writes A1,A2,A3 in cycles 1-3; IDLE in cycle 4; rr_ptr=3.
- All four requesters continuously valid, each never asserting last, MAX_BURST=4.
  - Required: grants go 0,1,2,3,0. Each grant writes exactly 4 beats, followed by 1 bubble cycle.
- Back-pressure: requester 1 is granted, then fifo_full=1 for 3 cycles mid-burst after beat 2.
  - Required: no writes and req_ready[1]=0 for those 3 cycles; beat_cnt stays 2; beats 3-4 written once full drops.
- Abandon: requester 0 is granted, then deasserts req_valid before its first beat.
  - Required: release after that cycle, zero writes, rr_ptr=1. Requester 3's pending req is granted next.
- Reset mid-burst: assert rst asynchronously during beat 2 of 4.
  - Required: fifo_write_en=0 and busy=0 immediately, with all outputs at their reset values.
  - After rst is released with requester 2 valid: requester 2 is granted, because rr_ptr=0 and requesters 0 and 1 are idle.
